// File: rtl/iter_shifter_pkg.sv
// Shared constants for the iterative operand shifter: shift-type codes,
// FSM state encoding and the clamp limits for over-range shift amounts.
package iter_shifter_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // One step beyond the data width flushes the carry to zero for logical shifts;
    // arithmetic shifts saturate at the width because further steps change nothing.
    localparam int SH_MAX_LSR = 33;
    localparam int SH_MAX_ASR = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Single-bit shift step: one iteration of LSL/LSR/ASR/ROR plus the bit
// shifted out, which becomes the shifter carry.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       type_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_o,
    output logic             carry_o
);

    always_comb begin
        d_o     = d_i;
        carry_o = d_i[0];
        case (type_i)
            SH_LSL: begin
                carry_o = d_i[WIDTH-1];
                d_o     = {d_i[WIDTH-2:0], 1'b0};
            end
            SH_LSR: d_o = {1'b0, d_i[WIDTH-1:1]};
            SH_ASR: d_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
            SH_ROR: d_o = {d_i[0], d_i[WIDTH-1:1]};
            default: d_o = d_i;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle replacement for a barrel shifter feeding ALU operand B: shifts
// one bit per clock under a small FSM, with ready/valid on both sides.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_type,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_cf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    localparam int CNT_W = 6;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic [1:0]       type_q, type_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] effAmt;
    logic             rorMultiple;
    logic [WIDTH-1:0] stepData;
    logic             stepCarry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .type_i  (type_q),
        .d_i     (data_q),
        .d_o     (stepData),
        .carry_o (stepCarry)
    );

    // Clamping the step count is what produces the ARM over-range results for free.
    always_comb begin
        effAmt = '0;
        case (in_type)
            SH_LSL, SH_LSR: effAmt = (in_amt > AMT_W'(SH_MAX_LSR)) ? CNT_W'(SH_MAX_LSR)
                                                                   : CNT_W'(in_amt);
            SH_ASR:         effAmt = (in_amt > AMT_W'(SH_MAX_ASR)) ? CNT_W'(SH_MAX_ASR)
                                                                   : CNT_W'(in_amt);
            SH_ROR:         effAmt = CNT_W'(in_amt[4:0]);
            default:        effAmt = '0;
        endcase
    end

    // A rotate by a non-zero multiple of 32 takes no steps but still reports bit 31.
    assign rorMultiple = (in_type == SH_ROR) && (in_amt != '0) && (in_amt[4:0] == 5'd0);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        type_d  = type_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    type_d  = in_type;
                    count_d = effAmt;
                    carry_d = rorMultiple ? in_data[WIDTH-1] : in_cf;
                    state_d = (effAmt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_d  = stepData;
                carry_d = stepCarry;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            type_q  <= SH_LSL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            type_q  <= type_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter: hand-computed vectors for every
// shift type and edge amount, plus backpressure and mid-shift reset scenarios.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_type;
    logic [7:0]  in_amt;
    logic        in_cf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;

    int checks = 0;
    int errors = 0;

    iter_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_type   (in_type),
        .in_amt    (in_amt),
        .in_cf     (in_cf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  t;
        logic [7:0]  a;
        logic        cf;
        logic [31:0] expD;
        logic        expC;
        int          expLat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC] = '{
        '{32'h0000_0001, 2'b00, 8'd4,   1'b0, 32'h0000_0010, 1'b0, 5},
        '{32'h8000_0001, 2'b01, 8'd1,   1'b0, 32'h4000_0000, 1'b1, 2},
        '{32'h8000_0001, 2'b01, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 33},
        '{32'h8000_0001, 2'b01, 8'd40,  1'b0, 32'h0000_0000, 1'b0, 34},
        '{32'h8000_0000, 2'b10, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 33},
        '{32'h0000_0003, 2'b11, 8'd1,   1'b0, 32'h8000_0001, 1'b1, 2},
        '{32'h0000_0003, 2'b11, 8'd32,  1'b1, 32'h0000_0003, 1'b0, 1},
        '{32'h0000_0001, 2'b00, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 33},
        '{32'h0000_0001, 2'b00, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 34},
        '{32'h0000_000F, 2'b11, 8'd36,  1'b0, 32'hF000_0000, 1'b1, 5},
        '{32'h4000_0000, 2'b10, 8'd3,   1'b1, 32'h0800_0000, 1'b0, 4},
        '{32'hA5A5_0F0F, 2'b00, 8'd0,   1'b1, 32'hA5A5_0F0F, 1'b1, 1},
        '{32'hA5A5_0F0F, 2'b01, 8'd0,   1'b1, 32'hA5A5_0F0F, 1'b1, 1},
        '{32'hA5A5_0F0F, 2'b10, 8'd0,   1'b1, 32'hA5A5_0F0F, 1'b1, 1},
        '{32'hA5A5_0F0F, 2'b11, 8'd0,   1'b1, 32'hA5A5_0F0F, 1'b1, 1},
        '{32'h8000_0000, 2'b00, 8'd1,   1'b0, 32'h0000_0000, 1'b1, 2}
    };

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Counts edges from the handshake edge (inclusive) until out_valid is seen.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] t,
                                 input logic [7:0] a, input logic cf, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_wait", 32'(guard < 100), 32'd1);
        in_data  = d;
        in_type  = t;
        in_amt   = a;
        in_cf    = cf;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(lat);
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic runVector(input int i);
        int lat;
        applyStimulus(vecs[i].d, vecs[i].t, vecs[i].a, vecs[i].cf, lat);
        checkOutput($sformatf("v%0d_data", i), out_data, vecs[i].expD);
        checkOutput($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vecs[i].expC));
        checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
        releaseResult();
    endtask

    initial begin
        int lat;
        logic [31:0] heldData;
        logic        heldCarry;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_type   = 2'b00;
        in_amt    = '0;
        in_cf     = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_carry", 32'(out_carry), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            runVector(i);
        end

        // Backpressure: a pending request must wait until the result is taken.
        applyStimulus(32'h8000_0001, 2'b01, 8'd1, 1'b0, lat);
        heldData  = 32'h4000_0000;
        heldCarry = 1'b1;
        @(negedge clk);
        in_data  = 32'h0000_0100;
        in_type  = 2'b01;
        in_amt   = 8'd4;
        in_cf    = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp%0d_data", c), out_data, heldData);
            checkOutput($sformatf("bp%0d_carry", c), 32'(out_carry), 32'(heldCarry));
            checkOutput($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp_next_data", out_data, 32'h0000_0010);
        checkOutput("bp_next_carry", 32'(out_carry), 32'd0);
        checkOutput("bp_next_latency", 32'(lat), 32'd5);
        releaseResult();

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        in_data  = 32'hFFFF_FFFF;
        in_type  = 2'b00;
        in_amt   = 8'd20;
        in_cf    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_data", out_data, 32'd0);
        checkOutput("mid_rst_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        applyStimulus(32'h1234_5678, 2'b11, 8'd4, 1'b0, lat);
        checkOutput("post_rst_data", out_data, 32'h8123_4567);
        checkOutput("post_rst_carry", 32'(out_carry), 32'd1);
        checkOutput("post_rst_latency", 32'(lat), 32'd5);
        releaseResult();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
